// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage and MEM/WB pipeline register of the RV32I core.
// Drives a word-only D-cache. Loads are extracted and extended here. Byte and
// halfword stores are done as read-modify-write: read the word, merge the new
// lane into wbuf, then write the whole word back from the RMW_WR state.
module mem_wb_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_regwrite,
  input  logic [4:0]        ex_mem_rd,
  input  logic              ex_mem_mem_read,
  input  logic              ex_mem_mem_write,
  input  logic [2:0]        ex_mem_funct3,
  input  logic [XLEN-1:0]   ex_mem_alu_result,
  input  logic [XLEN-1:0]   ex_mem_store_data,
  input  logic              ex_mem_jump,
  input  logic [XLEN-1:0]   ex_mem_pc_step,
  output logic              dcache_ren,
  output logic              dcache_wen,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [XLEN-1:0]   dcache_wdata,
  input  logic [XLEN-1:0]   dcache_rdata,
  input  logic              dcache_stall,
  output logic              mem_stall,
  output logic              mem_wb_regwrite,
  output logic [4:0]        mem_wb_rd,
  output logic [XLEN-1:0]   mem_wb_rd_data,
  output logic              misalign
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   wbuf_q, wbuf_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              regwrite_q, misalign_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              is_load, is_store, word_store, sub_store;
  logic              misaligned, access_done;
  logic [1:0]        byte_off;
  logic [ADDR_W-1:0] word_addr;
  logic [XLEN-1:0]   wb_value;

  // Pick the addressed lane of a read word and extend it to 32 bits.
  // Halfwords ignore addr[0], so a misaligned LH reads the aligned-down half.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      off,
                                                   input logic [2:0]      f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the low byte (SB) or low half (SH) of the store data onto the old word.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old_word,
                                                  input logic [XLEN-1:0] data,
                                                  input logic [1:0]      off,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] w;
    w = old_word;
    if (f3[0] == 1'b0) w[{off, 3'b000} +: 8] = data[7:0];
    else               w[{off[1], 4'b0000} +: 16] = data[15:0];
    return w;
  endfunction

  // A request with both read and write set is treated as a load, so ren and wen stay exclusive.
  assign is_load    = ex_mem_valid & ex_mem_mem_read;
  assign is_store   = ex_mem_valid & ex_mem_mem_write & ~ex_mem_mem_read;
  assign word_store = is_store & ex_mem_funct3[1];
  assign sub_store  = is_store & ~ex_mem_funct3[1];
  assign byte_off   = ex_mem_alu_result[1:0];
  assign word_addr  = ex_mem_alu_result[ADDR_W+1:2];

  assign misaligned = (is_load | is_store) &
                      (((ex_mem_funct3[1:0] == 2'b01) & byte_off[0]) |
                       ((ex_mem_funct3[1:0] == 2'b10) & (byte_off != 2'b00)));

  assign wb_value = ex_mem_jump     ? ex_mem_pc_step :
                    ex_mem_mem_read ? load_extract(dcache_rdata, byte_off, ex_mem_funct3) :
                                      ex_mem_alu_result;

  // Cache request, stall and next-state decode; reset silences every request.
  always_comb begin
    dcache_ren   = 1'b0;
    dcache_wen   = 1'b0;
    dcache_addr  = word_addr;
    dcache_wdata = ex_mem_store_data;
    mem_stall    = 1'b0;
    access_done  = 1'b0;
    state_d      = state_q;
    wbuf_d       = wbuf_q;
    waddr_d      = waddr_q;
    case (state_q)
      IDLE: begin
        if (is_load) begin
          dcache_ren  = 1'b1;
          mem_stall   = dcache_stall;
          access_done = ~dcache_stall;
        end else if (word_store) begin
          dcache_wen  = 1'b1;
          mem_stall   = dcache_stall;
          access_done = ~dcache_stall;
        end else if (sub_store) begin
          dcache_ren = 1'b1;
          mem_stall  = 1'b1;
          if (!dcache_stall) begin
            wbuf_d  = store_merge(dcache_rdata, ex_mem_store_data, byte_off, ex_mem_funct3);
            waddr_d = word_addr;
            state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        dcache_wen   = 1'b1;
        dcache_addr  = waddr_q;
        dcache_wdata = wbuf_q;
        mem_stall    = dcache_stall;
        if (!dcache_stall) begin
          access_done = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      dcache_ren = 1'b0;
      dcache_wen = 1'b0;
      mem_stall  = 1'b0;
    end
  end

  // FSM state, misalign pulse and MEM/WB register; a stall inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      rd_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= access_done & misaligned;
      if (!mem_stall) begin
        regwrite_q <= ex_mem_valid & ex_mem_regwrite & (ex_mem_rd != 5'd0);
        rd_q       <= ex_mem_rd;
        rd_data_q  <= wb_value;
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  // Merged RMW word and its address; pure data, no reset needed.
  always_ff @(posedge clk) begin
    wbuf_q  <= wbuf_d;
    waddr_q <= waddr_d;
  end

  assign mem_wb_regwrite = regwrite_q;
  assign mem_wb_rd       = rd_q;
  assign mem_wb_rd_data  = rd_data_q;
  assign misalign        = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a small word cache with random stalls, and a
// byte-addressed reference memory that predicts loads, stores and writeback.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, ex_mem_regwrite, ex_mem_mem_read, ex_mem_mem_write, ex_mem_jump;
  logic [4:0]  ex_mem_rd;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data, ex_mem_pc_step;
  logic        dcache_ren, dcache_wen, dcache_stall, mem_stall;
  logic [29:0] dcache_addr;
  logic [31:0] dcache_wdata, dcache_rdata;
  logic        mem_wb_regwrite, misalign;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_rd_data;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .ex_mem_funct3(ex_mem_funct3), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_jump(ex_mem_jump),
    .ex_mem_pc_step(ex_mem_pc_step),
    .dcache_ren(dcache_ren), .dcache_wen(dcache_wen), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_stall(dcache_stall),
    .mem_stall(mem_stall), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
    .mem_wb_rd_data(mem_wb_rd_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Cache: 16 words, aliased on word address bits [3:0]
  bit [31:0] mem [16];
  always_comb dcache_rdata = mem[dcache_addr[3:0]];
  always @(posedge clk) if (dcache_wen && !dcache_stall) mem[dcache_addr[3:0]] <= dcache_wdata;

  // Reference: 64 bytes, little-endian, same aliasing as the cache
  bit [7:0] ref_bytes [64];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [2:0] f3);
    int base;
    logic [31:0] u;
    case (f3[1:0])
      2'b00: begin
        u = {24'h0, ref_bytes[a]};
        if (!f3[2] && u[7]) u = u | 32'hFFFF_FF00;
      end
      2'b01: begin
        base = int'(a & 6'h3E);
        u = {16'h0, ref_bytes[base+1], ref_bytes[base]};
        if (!f3[2] && u[15]) u = u | 32'hFFFF_0000;
      end
      default: begin
        base = int'(a & 6'h3C);
        u = {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
      end
    endcase
    return u;
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [2:0] f3, input logic [31:0] d);
    int base;
    case (f3[1:0])
      2'b00: ref_bytes[a] = d[7:0];
      2'b01: begin
        base = int'(a & 6'h3E);
        ref_bytes[base] = d[7:0]; ref_bytes[base+1] = d[15:8];
      end
      default: begin
        base = int'(a & 6'h3C);
        for (int i = 0; i < 4; i++) ref_bytes[base+i] = d[8*i +: 8];
      end
    endcase
  endtask

  task automatic drive(input logic v, rw, input logic [4:0] rd, input logic mr, mw,
                       input logic [2:0] f3, input logic [31:0] alu, sd,
                       input logic j, input logic [31:0] pcs);
    ex_mem_valid = v; ex_mem_regwrite = rw; ex_mem_rd = rd;
    ex_mem_mem_read = mr; ex_mem_mem_write = mw; ex_mem_funct3 = f3;
    ex_mem_alu_result = alu; ex_mem_store_data = sd; ex_mem_jump = j; ex_mem_pc_step = pcs;
  endtask

  // Apply one instruction, hold it while the stage stalls, then check the writeback.
  // nstall >= 0: the first nstall cycles see a busy cache; nstall < 0: random busy cycles.
  task automatic run_op(input logic v, rw, input logic [4:0] rd, input logic mr, mw,
                        input logic [2:0] f3, input logic [31:0] alu, sd,
                        input logic j, input logic [31:0] pcs, input int nstall,
                        output int lat);
    logic [31:0] exp_data;
    logic        exp_rw, exp_mis, is_mem, stalled, done;
    logic [5:0]  a;
    int          k;
    a       = alu[5:0];
    is_mem  = v & (mr | mw);
    exp_rw  = v & rw & (rd != 5'd0);
    exp_mis = is_mem & (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)));
    if (j)       exp_data = pcs;
    else if (mr) exp_data = ref_load(a, f3);
    else         exp_data = alu;
    @(negedge clk);
    drive(v, rw, rd, mr, mw, f3, alu, sd, j, pcs);
    k = 0; done = 1'b0;
    while (!done && k < 60) begin
      dcache_stall = (nstall < 0) ? ($urandom_range(0, 2) == 0) : (k < nstall);
      #1;
      chk("ren_wen_excl", 32'(dcache_ren & dcache_wen), 32'd0);
      if (dcache_ren || dcache_wen) chk("req_addr", 32'(dcache_addr), 32'(alu[31:2]));
      if (!is_mem) chk("no_req", 32'(dcache_ren | dcache_wen), 32'd0);
      stalled = mem_stall;
      @(posedge clk); #1;
      k++;
      if (stalled) begin
        chk("bubble_regwrite", 32'(mem_wb_regwrite), 32'd0);
        chk("bubble_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    lat = k;
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL timeout: instruction still stalled after %0d cycles", k);
    end
    chk("wb_regwrite", 32'(mem_wb_regwrite), 32'(exp_rw));
    chk("wb_rd", 32'(mem_wb_rd), 32'(rd));
    chk("wb_rd_data", mem_wb_rd_data, exp_data);
    chk("misalign", 32'(misalign), 32'(exp_mis));
    if (v && mw && !mr) ref_store(a, f3, sd);
  endtask

  int lat;
  logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    dcache_stall = 1'b0;
    rst = 1'b1;
    drive(1, 1, 5'd3, 1, 0, 3'b010, 32'h40, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ren", 32'(dcache_ren), 32'd0);
    chk("rst_wen", 32'(dcache_wen), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_regwrite", 32'(mem_wb_regwrite), 32'd0);
    chk("rst_rd", 32'(mem_wb_rd), 32'd0);
    chk("rst_rd_data", mem_wb_rd_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    drive(0, 0, 5'd0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
    rst = 1'b0;

    // ALU result, jump, rd=0
    run_op(1, 1, 5'd5, 0, 0, 3'b000, 32'h1234, 32'h0, 0, 32'h0, 0, lat);
    chk("alu_lat", 32'(lat), 32'd1);
    chk("alu_data", mem_wb_rd_data, 32'h1234);
    run_op(1, 1, 5'd1, 0, 0, 3'b000, 32'h9999, 32'h0, 1, 32'h104, 0, lat);
    chk("jump_data", mem_wb_rd_data, 32'h104);
    run_op(1, 1, 5'd0, 0, 0, 3'b000, 32'h77, 32'h0, 0, 32'h0, 0, lat);
    chk("rd0_regwrite", 32'(mem_wb_regwrite), 32'd0);

    // Loads from 0x100
    run_op(1, 0, 5'd0, 0, 1, 3'b010, 32'h100, 32'h80FF_0000, 0, 32'h0, 0, lat);
    run_op(1, 1, 5'd6, 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h0, 0, lat);
    chk("lb_data", mem_wb_rd_data, 32'hFFFF_FF80);
    run_op(1, 1, 5'd6, 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h0, 0, lat);
    chk("lbu_data", mem_wb_rd_data, 32'h0000_0080);
    run_op(1, 1, 5'd6, 1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h0, 0, lat);
    chk("lh_data", mem_wb_rd_data, 32'hFFFF_80FF);

    // LW with three busy cycles
    run_op(1, 1, 5'd7, 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 3, lat);
    chk("lw_miss_lat", 32'(lat), 32'd4);
    chk("lw_miss_data", mem_wb_rd_data, 32'h80FF_0000);

    // SB by read-modify-write
    run_op(1, 0, 5'd0, 0, 1, 3'b010, 32'h200, 32'h1122_3344, 0, 32'h0, 0, lat);
    run_op(1, 0, 5'd0, 0, 1, 3'b000, 32'h201, 32'h0000_00AB, 0, 32'h0, 0, lat);
    chk("sb_hit_lat", 32'(lat), 32'd2);
    run_op(1, 1, 5'd8, 1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h0, 0, lat);
    chk("sb_result", mem_wb_rd_data, 32'h1122_AB44);

    // SH to the upper half, then misaligned LW
    run_op(1, 0, 5'd0, 0, 1, 3'b001, 32'h006, 32'h0000_BEEF, 0, 32'h0, 0, lat);
    chk("sh_misalign", 32'(misalign), 32'd0);
    run_op(1, 1, 5'd9, 1, 0, 3'b010, 32'h004, 32'h0, 0, 32'h0, 0, lat);
    chk("sh_result", mem_wb_rd_data, 32'hBEEF_0000);
    run_op(1, 1, 5'd9, 1, 0, 3'b010, 32'h002, 32'h0, 0, 32'h0, 0, lat);
    chk("lw_misalign", 32'(misalign), 32'd1);
    run_op(1, 1, 5'd4, 0, 0, 3'b000, 32'h5, 32'h0, 0, 32'h0, 0, lat);
    chk("misalign_one_pulse", 32'(misalign), 32'd0);

    // Reset while the SB is in its write phase: the write must be abandoned
    @(negedge clk);
    drive(1, 0, 5'd0, 0, 1, 3'b000, 32'h009, 32'h55, 0, 32'h0);
    dcache_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_wen", 32'(dcache_wen), 32'd0);
    chk("rst_mid_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_regwrite", 32'(mem_wb_regwrite), 32'd0);
    @(negedge clk);
    drive(0, 0, 5'd0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_mid_idle_wen", 32'(dcache_wen), 32'd0);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [4:0]  rd;
      logic [31:0] alu, sd, pcs;
      kind = $urandom_range(0, 4);
      rd = 5'($urandom); alu = $urandom; sd = $urandom; pcs = $urandom;
      case (kind)
        0: run_op(1, 1, rd, 0, 0, 3'($urandom), alu, sd, 0, pcs, -1, lat);
        1: run_op(1, 1, rd, 0, 0, 3'b000, alu, sd, 1, pcs, -1, lat);
        2: run_op(1, 1, rd, 1, 0, load_f3[$urandom_range(0, 4)], alu, sd, 0, pcs, -1, lat);
        3: run_op(1, 0, rd, 0, 1, 3'($urandom_range(0, 2)), alu, sd, 0, pcs, -1, lat);
        default: run_op(0, 1'($urandom), rd, 0, 0, 3'b000, alu, sd, 0, pcs, -1, lat);
      endcase
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++)
      chk("mem_final", mem[i],
          {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
